// File: rtl/bram_pkg.sv
// Shared constants for the hit-storage RAM instances (HNM, HCM, HIM).
// Defining BRAM_OUTPUT_REG_EN adds an output pipeline stage and raises READ_LATENCY to 2.
package bram_pkg;

    // Row address width and row width for each hit-storage instance
    localparam int ROWINDEXBITS_HNM = 8;
    localparam int NCOLS_HNM        = 64;
    localparam int ROWINDEXBITS_HCM = 10;
    localparam int NCOLS_HCM        = 24;
    localparam int ROWINDEXBITS_HIM = 12;
    localparam int NCOLS_HIM        = 48;

`ifdef BRAM_OUTPUT_REG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/dual_port_block_ram_if.sv
// Port A / port B bus bundle for dual_port_block_ram.
// The master modport belongs to the storage logic and the slave modport to the RAM.
interface dual_port_block_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;
    logic                  enb;
    logic                  web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, doutb
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, doutb
    );
endinterface

// File: rtl/bram_port.sv
// One RAM port: address range check, qualified write request and read-data register(s).
// When BRAM_OUTPUT_REG_EN is defined, a second enable-gated output stage is added.
module bram_port
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic                  in_range,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] rd_reg;

    assign in_range = ({1'b0, addr} < DEPTH_W);
    // Reset suppresses writes so a clear sequence interrupted by reset stops cleanly
    assign wr_req   = en && we && in_range && !reset;

    // rd_word is sampled before the same-edge write lands, giving read-first behaviour
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_reg <= '0;
        end else if (en) begin
            rd_reg <= rd_word;
        end
    end

`ifdef BRAM_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] pipe_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_reg <= '0;
        end else if (en) begin
            pipe_reg <= rd_reg;
        end
    end

    assign dout = pipe_reg;
`else
    assign dout = rd_reg;
`endif

endmodule

// File: rtl/dual_port_block_ram.sv
// True dual-port RAM for the hit-storage path: shared array plus two bram_port instances.
// Optional output pipeline stage via BRAM_OUTPUT_REG_EN (see bram_port).
module dual_port_block_ram
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    dual_port_block_ram_if.slave bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B
    logic                  port_en       [2];
    logic                  port_we       [2];
    logic [ADDR_WIDTH-1:0] port_addr     [2];
    logic [DATA_WIDTH-1:0] port_din      [2];
    logic [DATA_WIDTH-1:0] port_dout     [2];
    logic [DATA_WIDTH-1:0] rd_word       [2];
    logic                  port_in_range [2];
    logic                  wr_req        [2];
    logic                  wr_b_allowed;

    assign port_en[0]   = bus.ena;
    assign port_we[0]   = bus.wea;
    assign port_addr[0] = bus.addra;
    assign port_din[0]  = bus.dina;
    assign port_en[1]   = bus.enb;
    assign port_we[1]   = bus.web;
    assign port_addr[1] = bus.addrb;
    assign port_din[1]  = bus.dinb;
    assign bus.douta    = port_dout[0];
    assign bus.doutb    = port_dout[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rd_word[gi] = port_in_range[gi] ? mem[port_addr[gi]] : '0;

        bram_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DEPTH     (DEPTH)
        ) u_port (
            .clock   (clock),
            .reset   (reset),
            .en      (port_en[gi]),
            .we      (port_we[gi]),
            .addr    (port_addr[gi]),
            .rd_word (rd_word[gi]),
            .in_range(port_in_range[gi]),
            .wr_req  (wr_req[gi]),
            .dout    (port_dout[gi])
        );
    end

    // Same-row write collision: port A wins, port B's write is dropped
    assign wr_b_allowed = wr_req[1] && !(wr_req[0] && (port_addr[0] == port_addr[1]));

    always_ff @(posedge clock) begin
        if (wr_req[0]) begin
            mem[port_addr[0]] <= port_din[0];
        end
        if (wr_b_allowed) begin
            mem[port_addr[1]] <= port_din[1];
        end
    end

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Directed bench for dual_port_block_ram; a row-array/latency-queue model is checked every cycle.
// Works with or without BRAM_OUTPUT_REG_EN through bram_pkg::READ_LATENCY.
module tb_dual_port_block_ram;
    import bram_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;   // below 2**AW so out-of-range addresses can be exercised
    localparam int L     = READ_LATENCY;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dual_port_block_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: row contents plus, per port, the read results still travelling to dout
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] hist_a [$];
    logic [DW-1:0] hist_b [$];
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;
    logic          cmp_on = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_clear_outputs();
        hist_a = {};
        hist_b = {};
        repeat (L) begin
            hist_a.push_back('0);
            hist_b.push_back('0);
        end
    endtask

    // Applied once per rising edge using the inputs that were presented to it
    task automatic model_edge();
        logic [DW-1:0] ra, rb;
        int aa, ab;
        aa = int'(bus.addra);
        ab = int'(bus.addrb);
        if (reset) begin
            model_clear_outputs();
        end else begin
            ra = (aa < DEPTH) ? mem_m[aa] : '0;
            rb = (ab < DEPTH) ? mem_m[ab] : '0;
            if (bus.ena && bus.wea && aa < DEPTH)
                mem_m[aa] = bus.dina;
            if (bus.enb && bus.web && ab < DEPTH && !(bus.ena && bus.wea && aa == ab))
                mem_m[ab] = bus.dinb;
            if (bus.ena) begin
                hist_a.push_back(ra);
                void'(hist_a.pop_front());
            end
            if (bus.enb) begin
                hist_b.push_back(rb);
                void'(hist_b.pop_front());
            end
        end
        exp_a = hist_a[0];
        exp_b = hist_b[0];
    endtask

    task automatic step(input logic a_en, input logic a_we, input int a_addr, input logic [DW-1:0] a_din,
                        input logic b_en, input logic b_we, input int b_addr, input logic [DW-1:0] b_din,
                        input logic rst = 1'b0);
        bus.ena   = a_en;
        bus.wea   = a_we;
        bus.addra = AW'(a_addr);
        bus.dina  = a_din;
        bus.enb   = b_en;
        bus.web   = b_we;
        bus.addrb = AW'(b_addr);
        bus.dinb  = b_din;
        reset     = rst;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic read_a(input int addr);
        repeat (L) step(1'b1, 1'b0, addr, '0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic read_b(input int addr);
        repeat (L) step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, addr, '0);
    endtask

    // Single compare process: DUT outputs against the model on every falling edge
    always @(negedge clock) begin
        if (cmp_on) begin
            check("douta_vs_model", bus.douta, exp_a);
            check("doutb_vs_model", bus.doutb, exp_b);
        end
    end

    initial begin
        foreach (mem_m[i]) mem_m[i] = '0;
        model_clear_outputs();
        bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
        bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0;
        cmp_on = 1'b1;

        // Reset, with a write attempt that must be suppressed
        step(1'b1, 1'b1, 5, 32'hDEAD_0005, 1'b1, 1'b0, 5, '0, 1'b1);
        check("reset_douta", bus.douta, 32'h0);
        check("reset_doutb", bus.doutb, 32'h0);
        read_a(5);
        check("initial_read_a5", bus.douta, 32'h0);

        // Write then read on the other port
        step(1'b1, 1'b1, 3, 32'hA5A5_0001, 1'b0, 1'b0, 0, '0);
        read_b(3);
        check("write_then_read_b3", bus.doutb, 32'hA5A5_0001);

        // Read-modify-write: write A from doutb while B reads the same row
        step(1'b1, 1'b1, 7, 32'h0000_0010, 1'b0, 1'b0, 0, '0);
        read_b(7);
        check("rmw_initial_row7", bus.doutb, 32'h0000_0010);
        step(1'b1, 1'b1, 7, bus.doutb | 32'h1, 1'b1, 1'b0, 7, '0);
        repeat (L - 1) step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 7, '0);
        check("rmw_same_cycle_old", bus.doutb, 32'h0000_0010);
        read_b(7);
        check("rmw_reread_row7", bus.doutb, 32'h0000_0011);

        // Write collision on row 9: A wins
        step(1'b1, 1'b1, 9, 32'h0000_1111, 1'b1, 1'b1, 9, 32'h0000_2222);
        read_b(9);
        check("collision_read_b9", bus.doutb, 32'h0000_1111);
        read_a(9);
        check("collision_read_a9", bus.douta, 32'h0000_1111);

        // Simultaneous writes to different rows both land
        step(1'b1, 1'b1, 20, 32'h0000_AAAA, 1'b1, 1'b1, 21, 32'h0000_BBBB);
        repeat (L) step(1'b1, 1'b0, 20, '0, 1'b1, 1'b0, 21, '0);
        check("dual_write_row20", bus.douta, 32'h0000_AAAA);
        check("dual_write_row21", bus.doutb, 32'h0000_BBBB);

        // Enable gating: disabled write is dropped and doutb holds
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 4, 32'h0000_BEEF);
        check("gated_doutb_hold", bus.doutb, 32'h0000_BBBB);
        read_b(4);
        check("gated_row4_unchanged", bus.doutb, 32'h0);

        // Last valid row and out-of-range addresses
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b1, DEPTH - 1, 32'h0000_0999);
        read_a(DEPTH - 1);
        check("last_row_999", bus.douta, 32'h0000_0999);
        step(1'b1, 1'b1, DEPTH, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, '0);
        read_a(DEPTH);
        check("out_of_range_read", bus.douta, 32'h0);
        read_b(0);
        check("out_of_range_no_alias", bus.doutb, 32'h0);

        // Fill with ones, dual clear (A even rows, B odd rows), then scan every row
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b1, 2 * i, '1, 1'b1, 1'b1, 2 * i + 1, '1);
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b1, 2 * i, '0, 1'b1, 1'b1, 2 * i + 1, '0);
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b0, 2 * i, '0, 1'b1, 1'b0, 2 * i + 1, '0);
        read_b(DEPTH - 1);
        check("clear_last_row", bus.doutb, 32'h0);

        // Refill, clear rows 0..199, then reset lands on the rows 200/201 write
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b1, 2 * i, '1, 1'b1, 1'b1, 2 * i + 1, '1);
        for (int i = 0; i < 100; i++)
            step(1'b1, 1'b1, 2 * i, '0, 1'b1, 1'b1, 2 * i + 1, '0);
        step(1'b1, 1'b1, 200, '0, 1'b1, 1'b1, 201, '0, 1'b1);
        check("midclear_reset_douta", bus.douta, 32'h0);
        read_b(199);
        check("midclear_row199", bus.doutb, 32'h0);
        read_b(200);
        check("midclear_row200", bus.doutb, 32'hFFFF_FFFF);
        read_a(201);
        check("midclear_row201", bus.douta, 32'hFFFF_FFFF);
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b0, 2 * i, '0, 1'b1, 1'b0, 2 * i + 1, '0);
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
